// File: rtl/method_call_arbiter.sv
// Round-robin arbiter sharing one method call port among NUM_REQ clients.
// Sequences req/busy/return, routes the result back, aborts hung calls.
module method_call_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int ARG_WIDTH = 32,
   parameter int RET_WIDTH = 32,
   parameter int TIMEOUT   = 10000
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [NUM_REQ-1:0]             cli_req,
   input  logic [NUM_REQ*ARG_WIDTH-1:0]   cli_arg,
   output logic [NUM_REQ-1:0]             cli_done,
   output logic [NUM_REQ-1:0]             cli_err,
   output logic [RET_WIDTH-1:0]           cli_return,
   output logic [2:0]                     grant_id,
   output logic                           m_req,
   output logic [ARG_WIDTH-1:0]           m_arg,
   input  logic                           m_busy,
   input  logic [RET_WIDTH-1:0]           m_return
);

   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_RUN,
      S_DONE,
      S_ABORT
   } state_t;

   state_t                 r_state;
   state_t                 w_nxt;
   logic [2:0]             r_ptr;
   logic [2:0]             r_grant;
   logic [CW-1:0]          r_cnt;
   logic                   r_m_req;
   logic [ARG_WIDTH-1:0]   r_arg;
   logic [RET_WIDTH-1:0]   r_ret;
   logic [NUM_REQ-1:0]     r_done;
   logic [NUM_REQ-1:0]     r_err;

   logic [NUM_REQ-1:0]     w_rot;
   logic                   w_found;
   logic [2:0]             w_off;
   logic [3:0]             w_sum;
   logic [2:0]             w_pick;
   logic [ARG_WIDTH-1:0]   w_arg;
   logic [2:0]             w_ptr_inc;
   logic [NUM_REQ-1:0]     w_onehot;
   logic                   w_max;

   // Rotate requests so bit 0 is the pointer, take the first set bit.
   always_comb begin
      w_rot   = NUM_REQ'({cli_req, cli_req} >> r_ptr);
      w_found = 1'b0;
      w_off   = 3'd0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!w_found && w_rot[k]) begin
            w_found = 1'b1;
            w_off   = 3'(k);
         end
      end
   end

   always_comb begin
      w_sum  = {1'b0, r_ptr} + {1'b0, w_off};
      w_pick = w_sum[2:0];
      if (w_sum >= 4'(NUM_REQ)) begin
         w_pick = 3'(w_sum - 4'(NUM_REQ));
      end
   end

   assign w_arg     = cli_arg[int'(w_pick)*ARG_WIDTH +: ARG_WIDTH];
   assign w_ptr_inc = (r_grant == 3'(NUM_REQ - 1)) ? 3'd0
                                                   : r_grant + 3'd1;
   assign w_onehot  = NUM_REQ'(1) << r_grant;
   assign w_max     = (r_cnt == CW'(TIMEOUT));

   always_comb begin
      w_nxt = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (w_found) begin
               w_nxt = S_ISSUE;
            end
         end
         S_ISSUE: begin
            w_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (m_busy) begin
               w_nxt = S_RUN;
            end else if (w_max) begin
               w_nxt = S_ABORT;
            end
         end
         S_RUN: begin
            if (!m_busy) begin
               w_nxt = S_DONE;
            end else if (w_max) begin
               w_nxt = S_ABORT;
            end
         end
         S_DONE: begin
            w_nxt = S_IDLE;
         end
         S_ABORT: begin
            w_nxt = S_IDLE;
         end
         default: begin
            w_nxt = S_IDLE;
         end
      endcase
   end

   // Outputs are registered from the next state so they align with it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_ptr   <= 3'd0;
         r_grant <= 3'd0;
         r_cnt   <= '0;
         r_m_req <= 1'b0;
         r_arg   <= '0;
         r_ret   <= '0;
         r_done  <= '0;
         r_err   <= '0;
      end else begin
         r_state <= w_nxt;
         r_m_req <= (w_nxt == S_ISSUE);
         r_done  <= (w_nxt == S_DONE) ? w_onehot : '0;
         r_err   <= (w_nxt == S_ABORT) ? w_onehot : '0;
         if (r_state == S_IDLE && w_found) begin
            r_grant <= w_pick;
            r_arg   <= w_arg;
         end
         if (r_state == S_ISSUE) begin
            r_cnt <= '0;
         end else if ((r_state == S_WAIT || r_state == S_RUN) && !w_max) begin
            r_cnt <= r_cnt + CW'(1);
         end
         if (r_state == S_RUN && !m_busy) begin
            r_ret <= m_return;
         end
         if (w_nxt == S_DONE || w_nxt == S_ABORT) begin
            r_ptr <= w_ptr_inc;
         end
      end
   end

   assign m_req      = r_m_req;
   assign m_arg      = r_arg;
   assign cli_return = r_ret;
   assign cli_done   = r_done;
   assign cli_err    = r_err;
   assign grant_id   = r_grant;

endmodule

// File: tb/tb_method_call_arbiter.sv
// Scoreboard bench for method_call_arbiter with a behavioural callee.
// Expected completions are queued at stimulus time and checked on pulses.
module tb_method_call_arbiter;

   localparam int N  = 4;
   localparam int AW = 32;
   localparam int RW = 32;
   localparam int TO = 20;

   logic            clk;
   logic            reset;
   logic [N-1:0]    cli_req;
   logic [N*AW-1:0] cli_arg;
   logic [N-1:0]    cli_done;
   logic [N-1:0]    cli_err;
   logic [RW-1:0]   cli_return;
   logic [2:0]      grant_id;
   logic            m_req;
   logic [AW-1:0]   m_arg;
   logic            m_busy;
   logic [RW-1:0]   m_return;

   typedef struct packed {
      logic [2:0]  id;
      logic        err;
      logic [31:0] ret;
   } exp_t;

   exp_t q[$];
   int   n_chk;
   int   n_fail;

   logic hang;
   logic mode;
   int   busy_len;
   int   left;

   method_call_arbiter #(
      .NUM_REQ(N), .ARG_WIDTH(AW), .RET_WIDTH(RW), .TIMEOUT(TO)
   ) dut (
      .clk(clk), .reset(reset), .cli_req(cli_req), .cli_arg(cli_arg),
      .cli_done(cli_done), .cli_err(cli_err), .cli_return(cli_return),
      .grant_id(grant_id), .m_req(m_req), .m_arg(m_arg),
      .m_busy(m_busy), .m_return(m_return)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic expect_call(input int id, input logic err,
                              input logic [31:0] ret);
      exp_t e;
      e.id  = 3'(id);
      e.err = err;
      e.ret = ret;
      q.push_back(e);
   endtask

   task automatic wait_drain(input int max);
      int n;
      n = 0;
      while (q.size() != 0 && n < max) begin
         @(posedge clk);
         n++;
      end
      chk("drain", 64'(q.size()), 64'd0);
      @(negedge clk);
   endtask

   task automatic wait_mreq(input int max);
      int n;
      n = 0;
      while (!m_req && n < max) begin
         @(negedge clk);
         n++;
      end
      chk("mreq_seen", 64'(m_req), 64'd1);
   endtask

   // Callee: busy for busy_len cycles, result arg+1 or arg*2.
   always @(posedge clk) begin
      if (m_busy) begin
         if (left == 0) begin
            m_busy <= 1'b0;
         end else begin
            left <= left - 1;
         end
      end else if (m_req && !hang) begin
         m_busy   <= 1'b1;
         left     <= busy_len - 1;
         m_return <= mode ? m_arg * 2 : m_arg + 1;
      end
   end

   always @(negedge clk) begin
      if (reset && (|cli_done || |cli_err)) begin
         int   id;
         exp_t e;
         id = -1;
         for (int i = 0; i < N; i++) begin
            if (cli_done[i] || cli_err[i]) id = i;
         end
         chk("one_pulse", 64'($countones({cli_done, cli_err})), 64'd1);
         if (q.size() == 0) begin
            chk("unexpected_pulse", 64'(id), 64'hFFFF);
         end else begin
            e = q.pop_front();
            chk("pulse_kind", 64'(|cli_err), 64'(e.err));
            chk("pulse_id", 64'(id), 64'(e.id));
            chk("grant_id", 64'(grant_id), 64'(e.id));
            chk("cli_return", 64'(cli_return), 64'(e.ret));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=running exp=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int hi;
      m_busy   = 1'b0;
      m_return = '0;
      left     = 0;
      hang     = 1'b0;
      mode     = 1'b0;
      busy_len = 2;
      n_chk    = 0;
      n_fail   = 0;
      reset    = 1'b0;
      cli_req  = 4'b0001;
      cli_arg  = '0;
      cli_arg[0*AW +: AW] = 32'hA5A5_0001;

      // Reset held with a pending request.
      hi = 0;
      repeat (6) begin
         @(negedge clk);
         if (m_req) hi++;
      end
      chk("mreq_in_reset", 64'(hi), 64'd0);
      chk("rst_values", {cli_done, cli_err, cli_return, grant_id, m_arg},
          64'd0);
      expect_call(0, 1'b0, 32'hA5A5_0002);
      @(posedge clk);
      #1 reset = 1'b1;
      n = 1;
      @(negedge clk);
      while (!m_req && n < 10) begin
         @(posedge clk);
         n++;
         @(negedge clk);
      end
      chk("first_mreq_lat", 64'(n), 64'd2);
      chk("first_m_arg", 64'(m_arg), 64'hA5A5_0001);
      wait_drain(50);
      cli_req = '0;

      // Single call from requester 2.
      busy_len = 3;
      cli_arg[2*AW +: AW] = 32'h0000_0005;
      expect_call(2, 1'b0, 32'h0000_0006);
      cli_req = 4'b0100;
      wait_drain(50);
      cli_req = '0;

      // Reset pulsed while the call is running.
      busy_len = 8;
      cli_arg[1*AW +: AW] = 32'h77;
      cli_req = 4'b0010;
      n = 0;
      while (!m_busy && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("busy_before_rst", 64'(m_busy), 64'd1);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rst_mid_outs",
          {m_req, cli_done, cli_err, cli_return, grant_id, m_arg}, 64'd0);
      cli_req = '0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      n = 0;
      while (m_busy && n < 20) begin
         @(negedge clk);
         n++;
      end
      busy_len = 2;
      cli_arg[3*AW +: AW] = 32'h33;
      expect_call(3, 1'b0, 32'h34);
      cli_req = 4'b1000;
      wait_drain(50);
      cli_req = '0;

      // All four held: strict round-robin from pointer 0.
      mode = 1'b1;
      for (int i = 0; i < N; i++) cli_arg[i*AW +: AW] = 32'h100 + i;
      expect_call(0, 1'b0, 32'h200);
      expect_call(1, 1'b0, 32'h202);
      expect_call(2, 1'b0, 32'h204);
      expect_call(3, 1'b0, 32'h206);
      expect_call(0, 1'b0, 32'h200);
      cli_req = 4'b1111;
      wait_drain(200);
      cli_req = '0;

      // Callee never answers requester 1; requester 2 served next.
      mode = 1'b0;
      hang = 1'b1;
      cli_arg[1*AW +: AW] = 32'h11;
      cli_arg[2*AW +: AW] = 32'h22;
      expect_call(1, 1'b1, 32'h200);
      expect_call(2, 1'b0, 32'h23);
      cli_req = 4'b0110;
      wait_mreq(10);
      n = 0;
      while (n < 60) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         if (cli_err[1]) break;
      end
      chk("err_latency", 64'(n), 64'd22);
      hang = 1'b0;
      cli_req[1] = 1'b0;
      wait_drain(50);
      cli_req = '0;

      // Argument change and request drop after grant.
      busy_len = 4;
      cli_arg[0*AW +: AW] = 32'hCAFE_0000;
      expect_call(0, 1'b0, 32'hCAFE_0001);
      cli_req = 4'b0001;
      wait_mreq(10);
      cli_arg[0*AW +: AW] = 32'hDEAD_BEEF;
      cli_req = '0;
      repeat (2) @(negedge clk);
      chk("m_arg_stable", 64'(m_arg), 64'hCAFE_0000);
      wait_drain(50);

      repeat (5) @(negedge clk);
      chk("q_empty_end", 64'(q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
